apb_master_bridge: RTL
======================

Name: apb_master_bridge

Overview:
- APB initiator that turns single-word host commands into APB SETUP/ACCESS transfers toward the encoder/decoder register file (CTRL, DATA_IN, CODEWORD_WIDTH, NOISE at offsets 0x0/0x4/0x8/0xC).
- Host side uses valid/ready command and response channels.
- Supports PREADY wait states, a wait-state timeout and PSLVERR reporting.
- Used by the test/control subsystem to program and read back the codec.

Parameters:
AMBA_ADDR_WIDTH, 20, APB address width
AMBA_WORD, 32, APB data width
TIMEOUT_CYCLES, 16, max consecutive ACCESS cycles with PREADY low before abort (>=1)

Ports:
clk  input  1  single clock; all logic on rising edge
rst  input  1  reset, asynchronous, active-high
cmd_valid  input  1  host command present
cmd_ready  output  1  bridge can accept command
cmd_write  input  1  1=write, 0=read
cmd_addr  input  AMBA_ADDR_WIDTH  byte address
cmd_wdata  input  AMBA_WORD  write data
rsp_valid  output  1  response present
rsp_ready  input  1  host accepts response
rsp_rdata  output  AMBA_WORD  read data (0 for writes/aborts)
rsp_err  output  1  PSLVERR or timeout
PADDR  output  AMBA_ADDR_WIDTH  APB address
PWDATA  output  AMBA_WORD  APB write data
PWRITE  output  1  APB direction
PSEL  output  1  APB select
PENABLE  output  1  APB enable
PREADY  input  1  slave ready (tie high for zero-wait slaves)
PRDATA  input  AMBA_WORD  slave read data
PSLVERR  input  1  slave error (tie low if unused)

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset, asserted at any time:
  - State goes to IDLE.
  - PSEL, PENABLE, PWRITE, rsp_valid and rsp_err go to 0.
  - PADDR, PWDATA and rsp_rdata go to 0.
  - Wait counter clears.
  - An in-flight transfer is dropped with no response.
- All outputs are registered. cmd_ready = (state==IDLE), decoded directly from the state register.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - On cmd_valid&&cmd_ready, latch PADDR={cmd_addr[AW-1:2],2'b00}, PWDATA=cmd_wdata, PWRITE=cmd_write.
  - Set PSEL=1 and go to SETUP. PENABLE stays 0.
- SETUP: lasts exactly 1 cycle. Set PENABLE=1 and go to ACCESS. PADDR, PWDATA and PWRITE stay stable.
- ACCESS, edge with PREADY=1:
  - PSEL=0, PENABLE=0.
  - rsp_rdata=PWRITE?0:PRDATA; rsp_err=PSLVERR.
  - rsp_valid=1; go to RESP.
- ACCESS, edge with PREADY=0:
  - Wait counter increments.
  - When the counter reaches TIMEOUT_CYCLES (TIMEOUT_CYCLES consecutive low-PREADY ACCESS edges): PSEL=0, PENABLE=0, rsp_rdata=0, rsp_err=1, rsp_valid=1; go to RESP.
  - Counter clears on leaving ACCESS. Counter width is $clog2(TIMEOUT_CYCLES+1).
- RESP:
  - rsp_valid, rsp_rdata and rsp_err hold until rsp_ready=1.
  - On that edge: rsp_valid=0, rsp_err=0, go to IDLE.
  - rsp_rdata keeps its last value.
- Zero-wait throughput: 4 cycles per command.
  - Accept edge E0.
  - PSEL high after E0; PENABLE high after E1.
  - Response valid after E2.
  - IDLE after E3 if rsp_ready is held high.
- No new command is accepted while a response is pending (backpressure via cmd_ready=0).
- PADDR, PWDATA and PWRITE retain their last values while idle. They change only at command accept.
- PSEL and PENABLE are never both high outside ACCESS. PENABLE is never high without PSEL.
- PSLVERR and PRDATA are sampled only on the PREADY=1 ACCESS edge.

Test Plan:
- Write, PREADY tied 1: cmd {write=1, addr=0x00004, wdata=0xDEADBEEF} -> PSEL rises 1 cycle after accept, PENABLE 1 cycle later, PADDR=0x00004, PWDATA=0xDEADBEEF; then rsp_valid=1, rsp_err=0, rsp_rdata=0; cmd_ready back at cycle 4.
- Read-back against the codec register file (write 0xDEADBEEF to 0x4, then read 0x4) -> rsp_rdata=0xDEADBEEF, rsp_err=0. cmd_addr=0x7 -> PADDR=0x4.
- Wait states: PREADY low for 3 ACCESS cycles, then high with PRDATA=0x12345678 -> PENABLE high for 4 cycles, rsp_rdata=0x12345678, rsp_err=0.
- Timeout: TIMEOUT_CYCLES=16, PREADY held 0 -> PSEL/PENABLE drop after 16 ACCESS cycles; rsp_valid=1, rsp_err=1, rsp_rdata=0.
- Backpressure/error: PSLVERR=1 on ready edge, rsp_ready held 0 for 5 cycles -> rsp_valid, rsp_err=1 held stable; cmd_ready=0 throughout; IDLE 1 cycle after rsp_ready=1.
- Reset mid-ACCESS: assert rst asynchronously while PENABLE=1 -> PSEL, PENABLE and rsp_valid go 0 immediately without a clock edge; cmd_ready=1 after release; no response issued.

Source files
------------

// File: rtl/apb_master_bridge.sv
// APB initiator: turns single-word host commands into APB SETUP/ACCESS transfers.
// Handles PREADY wait states with a bounded timeout and reports PSLVERR back to the host.
module apb_master_bridge #(
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int AMBA_WORD       = 32,
  parameter int TIMEOUT_CYCLES  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic [AMBA_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [AMBA_WORD-1:0]       cmd_wdata,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [AMBA_WORD-1:0]       rsp_rdata,
  output logic                       rsp_err,
  output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  output logic [AMBA_WORD-1:0]       PWDATA,
  output logic                       PWRITE,
  output logic                       PSEL,
  output logic                       PENABLE,
  input  logic                       PREADY,
  input  logic [AMBA_WORD-1:0]       PRDATA,
  input  logic                       PSLVERR
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] wait_cnt;
  logic          xfer_done;
  logic          timeout_hit;

  // Byte-lane bits are dropped: the register file is word addressed.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^cmd_addr[1:0];

  assign cmd_ready   = (state == IDLE);
  assign xfer_done   = (state == ACCESS) && PREADY;
  // Abort on the TIMEOUT_CYCLES-th consecutive low-PREADY ACCESS edge.
  assign timeout_hit = (state == ACCESS) && !PREADY && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid)                state_nxt = SETUP;
      SETUP:                                 state_nxt = ACCESS;
      ACCESS:  if (xfer_done || timeout_hit) state_nxt = RESP;
      RESP:    if (rsp_ready)                state_nxt = IDLE;
      default:                               state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PADDR     <= '0;
      PWDATA    <= '0;
      PWRITE    <= 1'b0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            PADDR  <= {cmd_addr[AMBA_ADDR_WIDTH-1:2], 2'b00};
            PWDATA <= cmd_wdata;
            PWRITE <= cmd_write;
            PSEL   <= 1'b1;
          end
        end
        SETUP: PENABLE <= 1'b1;
        ACCESS: begin
          if (xfer_done) begin
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_rdata <= PWRITE ? '0 : PRDATA;
            rsp_err   <= PSLVERR;
            rsp_valid <= 1'b1;
            wait_cnt  <= '0;
          end else if (timeout_hit) begin
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            wait_cnt  <= '0;
          end else begin
            wait_cnt  <= wait_cnt + CW'(1);
          end
        end
        RESP: begin
          // rsp_rdata deliberately keeps its value after the handshake.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
